// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, register-0 id and the operand source / hazard encodings
// used by the operand fetch stage and its pending-write scoreboard.
package operand_fetch_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned NREG   = 2 ** REG_AW;
    localparam int unsigned CTRL_W = 8;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_WB   = 2'd1,
        SEL_RF   = 2'd2
    } fwdSel_e;

    typedef struct packed {
        logic raw1;
        logic raw2;
        logic waw;
    } hazard_t;

    // Register 0 and unused sources read as zero; writeback bypass beats the array.
    function automatic fwdSel_e resolveSel(
        input logic [REG_AW-1:0] src,
        input logic              useSrc,
        input logic              wbValid,
        input logic [REG_AW-1:0] wbDst
    );
        if (src == ZERO_REG || !useSrc) begin
            return SEL_ZERO;
        end
        if (wbValid && wbDst == src) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_regfile_scoreboard.sv
// One pending bit per architectural register; lookups report pending bits
// that are not being cleared by this cycle's writeback.
module regfile_scoreboard
    import operand_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              setEn,
    input  logic [REG_AW-1:0] setId,
    input  logic              wbClrEn,
    input  logic [REG_AW-1:0] wbClrId,
    input  logic              killClrEn,
    input  logic [REG_AW-1:0] killClrId,
    input  logic [REG_AW-1:0] lookSrc1,
    input  logic [REG_AW-1:0] lookSrc2,
    input  logic [REG_AW-1:0] lookDst,
    output logic              busySrc1,
    output logic              busySrc2,
    output logic              busyDst
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] clrMask;
    logic [NREG-1:0] setMask;

    always_comb begin
        clrMask = '0;
        setMask = '0;
        if (wbClrEn) begin
            clrMask[wbClrId] = 1'b1;
        end
        if (killClrEn) begin
            clrMask[killClrId] = 1'b1;
        end
        if (setEn && setId != ZERO_REG) begin
            setMask[setId] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clrMask) | setMask;
        end
    end

    assign busySrc1 = pending[lookSrc1] && !(wbClrEn && wbClrId == lookSrc1);
    assign busySrc2 = pending[lookSrc2] && !(wbClrEn && wbClrId == lookSrc2);
    assign busyDst  = pending[lookDst]  && !(wbClrEn && wbClrId == lookDst);

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, bypasses same-cycle writeback,
// stalls on RAW/WAW against in-flight writes and registers operands for execute.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_src1,
    input  logic [REG_AW-1:0] in_src2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_wr,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [REG_AW-1:0] rf_src1,
    output logic [REG_AW-1:0] rf_src2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_wr,
    output logic [CTRL_W-1:0] out_ctrl
);

    fwdSel_e           sel1;
    fwdSel_e           sel2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    hazard_t           haz;
    logic              busy1;
    logic              busy2;
    logic              busyDst;
    logic              accept;
    logic              killHeld;

    assign rf_src1 = in_src1;
    assign rf_src2 = in_src2;

    assign sel1 = resolveSel(in_src1, in_use1, wb_valid, wb_dst);
    assign sel2 = resolveSel(in_src2, in_use2, wb_valid, wb_dst);

    always_comb begin
        case (sel1)
            SEL_WB:  op1 = wb_data;
            SEL_RF:  op1 = rf_data1;
            default: op1 = '0;
        endcase
        case (sel2)
            SEL_WB:  op2 = wb_data;
            SEL_RF:  op2 = rf_data2;
            default: op2 = '0;
        endcase
    end

    always_comb begin
        haz.raw1 = in_use1 && in_src1 != ZERO_REG && busy1;
        haz.raw2 = in_use2 && in_src2 != ZERO_REG && busy2;
        haz.waw  = in_wr   && in_dst  != ZERO_REG && busyDst;
    end

    // rst gates in_ready directly so it drops the moment reset asserts.
    assign in_ready = rst && !flush && !(haz.raw1 || haz.raw2 || haz.waw)
                    && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // A held instruction dropped by flush never writes back; release its destination.
    assign killHeld = flush && out_valid && out_wr && out_dst != ZERO_REG && !out_ready;

    regfile_scoreboard uScoreboard (
        .clk       (clk),
        .rst       (rst),
        .setEn     (accept && in_wr),
        .setId     (in_dst),
        .wbClrEn   (wb_valid),
        .wbClrId   (wb_dst),
        .killClrEn (killHeld),
        .killClrId (out_dst),
        .lookSrc1  (in_src1),
        .lookSrc2  (in_src2),
        .lookDst   (in_dst),
        .busySrc1  (busy1),
        .busySrc2  (busy2),
        .busyDst   (busyDst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_dst   <= '0;
            out_wr    <= 1'b0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1;
            out_op2   <= op2;
            out_dst   <= in_dst;
            out_wr    <= in_wr;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench: a behavioural model predicts accepts and operands,
// a separate monitor compares each transfer to execute.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_src1, in_src2, in_dst;
    logic              in_use1, in_use2, in_wr;
    logic [CTRL_W-1:0] in_ctrl;
    logic [REG_AW-1:0] rf_src1, rf_src2;
    logic [DATA_W-1:0] rf_data1, rf_data2;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1, out_op2;
    logic [REG_AW-1:0] out_dst;
    logic              out_wr;
    logic [CTRL_W-1:0] out_ctrl;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
        .in_dst(in_dst), .in_wr(in_wr), .in_ctrl(in_ctrl),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_dst(out_dst),
        .out_wr(out_wr), .out_ctrl(out_ctrl)
    );

    // Register file model; entry 0 deliberately holds junk the stage must ignore.
    logic [DATA_W-1:0] rfMem [NREG];
    assign rf_data1 = rfMem[rf_src1];
    assign rf_data2 = rfMem[rf_src2];

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [REG_AW-1:0] dst;
        logic              wr;
        logic [CTRL_W-1:0] ctrl;
    } outTxn_t;

    typedef struct packed {
        logic              iv;
        logic [REG_AW-1:0] s1;
        logic [REG_AW-1:0] s2;
        logic              u1;
        logic              u2;
        logic [REG_AW-1:0] d;
        logic              w;
        logic [CTRL_W-1:0] c;
        logic              wbv;
        logic [REG_AW-1:0] wbd;
        logic [DATA_W-1:0] wbdat;
        logic              fl;
        logic              ordy;
    } stim_t;

    outTxn_t           expQ[$];
    logic [NREG-1:0]   modelPend;
    logic              applyWb;
    logic [REG_AW-1:0] applyWbDst;
    logic [DATA_W-1:0] applyWbData;
    int unsigned       total = 0;
    int unsigned       bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic busyRef(input logic [REG_AW-1:0] r);
        return r != ZERO_REG && modelPend[r] && !(wb_valid && wb_dst == r);
    endfunction

    function automatic logic [DATA_W-1:0] refOperand(input logic [REG_AW-1:0] src, input logic u);
        if (src == ZERO_REG || !u) return '0;
        if (wb_valid && wb_dst == src) return wb_data;
        return rfMem[src];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ordy = 1'b1;
        return s;
    endfunction

    // Called at posedge+1; drives one cycle, predicts it, returns at the next posedge+1.
    task automatic step(input stim_t s);
        logic    held, hazard, expRdy, acc;
        outTxn_t t, k;
        if (applyWb && applyWbDst != ZERO_REG) rfMem[applyWbDst] = applyWbData;
        applyWb   = 1'b0;
        in_valid  = s.iv;  in_src1 = s.s1;  in_src2 = s.s2;
        in_use1   = s.u1;  in_use2 = s.u2;  in_dst  = s.d;
        in_wr     = s.w;   in_ctrl = s.c;
        wb_valid  = s.wbv; wb_dst  = s.wbd; wb_data = s.wbdat;
        flush     = s.fl;  out_ready = s.ordy;
        #3;
        held = expQ.size() != 0;
        check("out_valid", 64'(out_valid), 64'(held));
        check("pending", 64'(dut.uScoreboard.pending), 64'(modelPend));
        check("rf_src", 64'({rf_src1, rf_src2}), 64'({s.s1, s.s2}));
        hazard = (s.u1 && busyRef(s.s1)) || (s.u2 && busyRef(s.s2)) || (s.w && busyRef(s.d));
        expRdy = !s.fl && !hazard && (!held || s.ordy);
        check("in_ready", 64'(in_ready), 64'(expRdy));
        acc = s.iv && expRdy;
        if (s.fl && held && !s.ordy) begin
            k = expQ.pop_front();
            if (k.wr && k.dst != ZERO_REG) modelPend[k.dst] = 1'b0;
        end
        if (s.wbv) modelPend[s.wbd] = 1'b0;
        if (acc) begin
            t.op1  = refOperand(s.s1, s.u1);
            t.op2  = refOperand(s.s2, s.u2);
            t.dst  = s.d;
            t.wr   = s.w;
            t.ctrl = s.c;
            expQ.push_back(t);
            if (s.w && s.d != ZERO_REG) modelPend[s.d] = 1'b1;
        end
        if (s.wbv) begin
            applyWb     = 1'b1;
            applyWbDst  = s.wbd;
            applyWbData = s.wbdat;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer to execute must match the oldest predicted result.
    initial begin
        outTxn_t t;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transfer: got dst=%0h expected none at %0t", out_dst, $time);
                end else begin
                    t = expQ.pop_front();
                    check("txn", 64'({out_op1, out_op2, out_dst, out_wr, out_ctrl}), 64'(t));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        stim_t       s;
        logic [DATA_W-1:0] saved;
        int unsigned start;
        rst = 1'b0;
        s = idle();
        in_valid = 0; in_src1 = 0; in_src2 = 0; in_use1 = 0; in_use2 = 0;
        in_dst = 0; in_wr = 0; in_ctrl = 0; wb_valid = 0; wb_dst = 0; wb_data = 0;
        flush = 0; out_ready = 0;
        for (int i = 0; i < int'(NREG); i++) rfMem[i] = 16'($urandom);
        rfMem[0]  = 16'hFFFF;
        rfMem[3]  = 16'h0000;
        modelPend = '0;
        applyWb   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(0));
        check("reset outs", 64'({out_op1, out_op2, out_dst, out_wr, out_ctrl}), 64'(0));
        rst = 1'b1;

        // Zero register operand, then flush of a held writer.
        s = idle(); s.iv = 1; s.s1 = 0; s.u1 = 1; s.d = 9; s.w = 1; s.c = 8'h5A; s.ordy = 0;
        step(s);
        check("zero op1", 64'(out_op1), 64'(0));
        check("pend9 set", 64'(dut.uScoreboard.pending[9]), 64'(1));
        s = idle(); s.fl = 1; s.ordy = 0;
        step(s);
        check("flush valid", 64'(out_valid), 64'(0));
        check("flush pend9", 64'(dut.uScoreboard.pending[9]), 64'(0));

        // Forwarding from same-cycle writeback.
        s = idle(); s.iv = 1; s.d = 3; s.w = 1;
        step(s);
        s = idle(); s.iv = 1; s.s1 = 3; s.u1 = 1; s.wbv = 1; s.wbd = 3; s.wbdat = 16'hBEEF;
        step(s);
        check("fwd op1", 64'(out_op1), 64'(16'hBEEF));
        check("fwd pend3", 64'(dut.uScoreboard.pending[3]), 64'(0));

        // RAW stall until writeback of r5.
        s = idle(); s.iv = 1; s.d = 5; s.w = 1;
        step(s);
        s = idle(); s.iv = 1; s.s2 = 5; s.u2 = 1;
        step(s);
        step(s);
        s.wbv = 1; s.wbd = 5; s.wbdat = 16'h1234;
        step(s);
        check("raw op2", 64'(out_op2), 64'(16'h1234));

        // Backpressure: outputs hold for 3 cycles, then back-to-back transfer.
        s = idle(); s.iv = 1; s.s1 = 6; s.u1 = 1; s.c = 8'hC1;
        step(s);
        saved = out_op1;
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iv = 1; s.s1 = 4'(i + 1); s.c = 8'hC2; s.ordy = 0;
            step(s);
            check("hold op1", 64'(out_op1), 64'(saved));
            check("hold ctrl", 64'(out_ctrl), 64'(8'hC1));
        end
        s = idle(); s.iv = 1; s.c = 8'hC3;
        step(s);
        check("b2b valid", 64'(out_valid), 64'(1));
        check("b2b ctrl", 64'(out_ctrl), 64'(8'hC3));

        // WAW stall, then same-cycle set/clear keeps r7 pending.
        s = idle(); s.iv = 1; s.d = 7; s.w = 1;
        step(s);
        step(s);
        s.wbv = 1; s.wbd = 7; s.wbdat = 16'h0777;
        step(s);
        check("waw pend7", 64'(dut.uScoreboard.pending[7]), 64'(1));

        // Asynchronous reset while an instruction is held.
        s = idle(); s.iv = 1; s.d = 11; s.w = 1; s.ordy = 0;
        step(s);
        #1 rst = 1'b0;
        #1;
        check("arst out_valid", 64'(out_valid), 64'(0));
        check("arst in_ready", 64'(in_ready), 64'(0));
        check("arst pending", 64'(dut.uScoreboard.pending), 64'(0));
        expQ.delete();
        modelPend = '0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            s       = idle();
            s.iv    = ($urandom_range(0, 3) != 0);
            s.s1    = 4'($urandom);
            s.s2    = 4'($urandom);
            s.u1    = 1'($urandom);
            s.u2    = 1'($urandom);
            s.d     = 4'($urandom);
            s.w     = 1'($urandom);
            s.c     = 8'($urandom);
            s.wbv   = ($urandom_range(0, 2) == 0);
            s.wbd   = 4'($urandom);
            s.wbdat = 16'($urandom);
            s.fl    = ($urandom_range(0, 19) == 0);
            s.ordy  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, NREG - 1);
                for (int unsigned i = 0; i < NREG; i++) begin
                    if (modelPend[(start + i) % NREG]) begin
                        s.wbd = 4'((start + i) % NREG);
                        break;
                    end
                end
            end
            step(s);
        end

        s = idle();
        repeat (4) step(s);
        check("drained", 64'(expQ.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
